// File: rtl/mic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mic_pkg
// Description : Shared constants and types for the I2S microphone receiver:
//               default sample width and FIFO depth, bit-counter width, the
//               receive FSM state encoding and a saturating counter helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mic_pkg;

    localparam int DEFAULT_SAMPLE_W   = 16;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int BIT_CNT_W          = 6;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } mic_state_e;

    // Bit counter sticks at all-ones so very long slots never wrap back
    // into the "still shifting" range.
    function automatic logic [BIT_CNT_W-1:0] bit_cnt_inc(input logic [BIT_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mic_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mic_sample_fifo
// Description : Synchronous show-ahead FIFO for captured stereo frames.
//               Head data and valid are registered; a pop takes effect on
//               the registered head in the same edge, a push becomes visible
//               one edge after it is written.
// Ports       : clk, rst_n (sync, active-low), flush, push/push_data,
//               pop, head_data/head_valid (registered head), full
// Revision    : 1.0 - initial release
// ============================================================================
module mic_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             full
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_head;
    logic             r_valid;

    logic [c_aw:0]    w_count;
    logic [c_aw:0]    w_count_after_pop;
    logic [c_aw-1:0]  w_rd_idx_next;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_count           = r_wr_ptr - r_rd_ptr;
    assign full              = (w_count == (c_aw+1)'(DEPTH));
    // Pops are only honoured while the consumer can actually see a head.
    assign w_pop_ok          = pop & r_valid;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push_ok         = push & (~full | w_pop_ok);
    assign w_count_after_pop = w_count - (c_aw+1)'(w_pop_ok);
    assign w_rd_idx_next     = r_rd_ptr[c_aw-1:0] + c_aw'(w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst_n && !flush && w_push_ok) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Head reflects storage after this edge's pop; an entry written
            // on this edge shows up on the next one.
            r_valid <= (w_count_after_pop != '0);
            r_head  <= (w_count_after_pop != '0) ? r_mem[w_rd_idx_next] : '0;
        end
    end

    assign head_data  = r_head;
    assign head_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/i2s_mic_receiver.sv
`default_nettype none
// ============================================================================
// Module      : i2s_mic_receiver
// Description : Oversampling I2S receiver for the microphone ADC. Captures
//               MSB-first left/right words, keeps SAMPLE_W bits of each and
//               queues {left, right} frames in a show-ahead FIFO.
// Ports       : clk27, hw_reset_n (sync, active-low), enable,
//               mic_bclk/mic_lrck/mic_data (async I2S),
//               sample_data/sample_valid/sample_retrieved (FIFO head/pop),
//               overrun, overrun_sticky, frame_error (status)
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_mic_receiver
    import mic_pkg::*;
#(
    parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk27,
    input  logic                  hw_reset_n,
    input  logic                  enable,
    input  logic                  mic_bclk,
    input  logic                  mic_lrck,
    input  logic                  mic_data,
    output logic [2*SAMPLE_W-1:0] sample_data,
    output logic                  sample_valid,
    input  logic                  sample_retrieved,
    output logic                  overrun,
    output logic                  overrun_sticky,
    output logic                  frame_error
);

    localparam logic [BIT_CNT_W-1:0] c_sample_w = BIT_CNT_W'(SAMPLE_W);

    logic                  r_bclk_s1, r_bclk_s2, r_bclk_d;
    logic                  r_lrck_s1, r_lrck_s2, r_lrck_prev;
    logic                  r_data_s1, r_data_s2;

    mic_state_e            r_state;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [SAMPLE_W-1:0]   r_shift;
    logic [SAMPLE_W-1:0]   r_left;
    logic                  r_left_ok;
    logic                  r_push;
    logic [2*SAMPLE_W-1:0] r_push_data;
    logic                  r_frame_error;
    logic                  r_overrun;
    logic                  r_overrun_sticky;

    logic                  w_bclk_rise;
    logic                  w_lr_rise;
    logic                  w_lr_fall;
    logic [BIT_CNT_W-1:0]  w_cnt_inc;
    logic                  w_word_ok;
    logic [SAMPLE_W-1:0]   w_shift_next;
    logic                  w_full;
    logic                  w_overrun;

    assign w_bclk_rise  = r_bclk_s2 & ~r_bclk_d;
    assign w_lr_rise    = r_lrck_s2 & ~r_lrck_prev;
    assign w_lr_fall    = ~r_lrck_s2 & r_lrck_prev;
    // The lrck-change edge still carries the last bit of the ending word,
    // so word length and the final shift both include the current bit.
    assign w_cnt_inc    = bit_cnt_inc(r_bit_cnt);
    assign w_word_ok    = (w_cnt_inc >= c_sample_w);
    assign w_shift_next = (r_bit_cnt < c_sample_w) ? {r_shift[SAMPLE_W-2:0], r_data_s2} : r_shift;
    assign w_overrun    = enable & r_push & w_full & ~(sample_retrieved & sample_valid);

    always_ff @(posedge clk27) begin
        if (!hw_reset_n) begin
            r_bclk_s1        <= 1'b0;
            r_bclk_s2        <= 1'b0;
            r_bclk_d         <= 1'b0;
            r_lrck_s1        <= 1'b0;
            r_lrck_s2        <= 1'b0;
            r_lrck_prev      <= 1'b0;
            r_data_s1        <= 1'b0;
            r_data_s2        <= 1'b0;
            r_state          <= ST_SYNC;
            r_bit_cnt        <= '0;
            r_shift          <= '0;
            r_left           <= '0;
            r_left_ok        <= 1'b0;
            r_push           <= 1'b0;
            r_push_data      <= '0;
            r_frame_error    <= 1'b0;
            r_overrun        <= 1'b0;
            r_overrun_sticky <= 1'b0;
        end else begin
            r_bclk_s1     <= mic_bclk;
            r_bclk_s2     <= r_bclk_s1;
            r_bclk_d      <= r_bclk_s2;
            r_lrck_s1     <= mic_lrck;
            r_lrck_s2     <= r_lrck_s1;
            r_data_s1     <= mic_data;
            r_data_s2     <= r_data_s1;
            r_push        <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= w_overrun;

            // Tracked even while disabled so re-enabling needs a genuine
            // fresh 1->0 lrck transition before capture resumes.
            if (w_bclk_rise) begin
                r_lrck_prev <= r_lrck_s2;
            end

            if (!enable) begin
                r_state          <= ST_SYNC;
                r_bit_cnt        <= '0;
                r_shift          <= '0;
                r_left_ok        <= 1'b0;
                r_overrun_sticky <= 1'b0;
            end else begin
                if (w_overrun) begin
                    r_overrun_sticky <= 1'b1;
                end
                if (w_bclk_rise) begin
                    case (r_state)
                        ST_SYNC: begin
                            r_bit_cnt <= '0;
                            r_shift   <= '0;
                            if (w_lr_fall) begin
                                r_state <= ST_LEFT;
                            end
                        end
                        ST_LEFT: begin
                            if (w_lr_rise) begin
                                r_left        <= w_shift_next;
                                r_left_ok     <= w_word_ok;
                                r_frame_error <= ~w_word_ok;
                                r_bit_cnt     <= '0;
                                r_shift       <= '0;
                                r_state       <= ST_RIGHT;
                            end else begin
                                r_shift   <= w_shift_next;
                                r_bit_cnt <= w_cnt_inc;
                            end
                        end
                        ST_RIGHT: begin
                            if (w_lr_fall) begin
                                r_frame_error <= ~w_word_ok;
                                r_push        <= w_word_ok & r_left_ok;
                                r_push_data   <= {r_left, w_shift_next};
                                r_bit_cnt     <= '0;
                                r_shift       <= '0;
                                r_state       <= ST_LEFT;
                            end else begin
                                r_shift   <= w_shift_next;
                                r_bit_cnt <= w_cnt_inc;
                            end
                        end
                        default: begin
                            r_state <= ST_SYNC;
                        end
                    endcase
                end
            end
        end
    end

    mic_sample_fifo #(
        .WIDTH (2*SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk27),
        .rst_n      (hw_reset_n),
        .flush      (~enable),
        .push       (r_push),
        .push_data  (r_push_data),
        .pop        (sample_retrieved),
        .head_data  (sample_data),
        .head_valid (sample_valid),
        .full       (w_full)
    );

    assign overrun        = r_overrun;
    assign overrun_sticky = r_overrun_sticky;
    assign frame_error    = r_frame_error;

endmodule
`default_nettype wire
